// File: rtl/img_seq_pkg.sv
// img_seq_pkg: shared state encoding, default frame geometry and width helper for the image feed sequencer
package img_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_IMG,
        WAIT_CREDIT,
        SEND_PAD,
        DRAIN
    } state_t;

    localparam int DEF_IMG_W         = 512;
    localparam int DEF_IMG_H         = 512;
    localparam int DEF_PREFILL_LINES = 4;
    localparam int DEF_PAD_LINES     = 2;
    localparam int DEF_DW            = 8;
    localparam int DEF_CREDIT_MAX    = 7;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_credit_counter.sv
// line_credit_counter: turns rising edges of the core line-freed interrupt into a saturating credit count
module line_credit_counter
    import img_seq_pkg::*;
#(
    parameter int CREDIT_MAX = DEF_CREDIT_MAX
) (
    input  logic axi_clk,
    input  logic axi_rst,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_intr,
    input  logic i_consume,
    output logic o_avail,
    output logic o_credit_ovf
);

    localparam int KW = cw(CREDIT_MAX + 1);

    logic [KW-1:0] credits;
    logic          intr_q;
    logic          rise;
    logic          sat;

    // an edge arriving this cycle already counts as available so lines chain without a bubble
    always_comb begin
        rise    = i_en && i_intr && !intr_q;
        sat     = credits == KW'(CREDIT_MAX);
        o_avail = rise || (credits != '0);
    end

    // edge history, credit accumulation/consumption and the sticky overflow flag
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            intr_q       <= 1'b0;
            credits      <= '0;
            o_credit_ovf <= 1'b0;
        end else begin
            intr_q <= i_intr;
            if (i_clr) begin
                credits      <= '0;
                o_credit_ovf <= 1'b0;
            end else begin
                credits <= credits + KW'(rise && !sat) - KW'(i_consume);
                if (rise && sat)
                    o_credit_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_feed_sequencer.sv
// image_feed_sequencer: gates a raster frame plus trailing zero lines into the 3x3 filter core under line credits
module image_feed_sequencer
    import img_seq_pkg::*;
#(
    parameter int IMG_W         = DEF_IMG_W,
    parameter int IMG_H         = DEF_IMG_H,
    parameter int PREFILL_LINES = DEF_PREFILL_LINES,
    parameter int PAD_LINES     = DEF_PAD_LINES,
    parameter int DW            = DEF_DW,
    parameter int CREDIT_MAX    = DEF_CREDIT_MAX
) (
    input  logic          axi_clk,
    input  logic          axi_rst,
    input  logic          i_start,
    input  logic [DW-1:0] s_data,
    input  logic          s_data_valid,
    output logic          s_data_ready,
    output logic [DW-1:0] m_data,
    output logic          m_data_valid,
    input  logic          m_data_ready,
    input  logic          i_intr,
    input  logic          i_out_valid,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_credit_ovf
);

    localparam int CW = cw(IMG_W);
    localparam int LW = cw(IMG_H + PAD_LINES + 1);
    localparam int OW = cw(IMG_W * IMG_H + 1);
    localparam logic [OW-1:0] TOTAL = OW'(IMG_W * IMG_H);
    localparam logic [LW-1:0] LAST  = LW'(IMG_H + PAD_LINES);

    state_t        state;
    logic [CW-1:0] col;
    logic [LW-1:0] line_idx;
    logic [LW-1:0] nline;
    logic [OW-1:0] out_cnt;
    logic          start;
    logic          xfer;
    logic          line_end;
    logic          avail;
    logic          consume;

    line_credit_counter #(
        .CREDIT_MAX(CREDIT_MAX)
    ) u_credit (
        .axi_clk     (axi_clk),
        .axi_rst     (axi_rst),
        .i_en        (state != IDLE),
        .i_clr       (start),
        .i_intr      (i_intr),
        .i_consume   (consume),
        .o_avail     (avail),
        .o_credit_ovf(o_credit_ovf)
    );

    // zero-latency stream steering and the line-boundary credit decision
    always_comb begin
        start        = state == IDLE && i_start;
        xfer         = (state == SEND_IMG && s_data_valid && m_data_ready) || (state == SEND_PAD && m_data_ready);
        line_end     = xfer && col == CW'(IMG_W - 1);
        nline        = line_idx + 1'b1;
        consume      = avail && (state == WAIT_CREDIT || (line_end && nline >= LW'(PREFILL_LINES) && nline != LAST));
        s_data_ready = state == SEND_IMG && m_data_ready;
        m_data_valid = (state == SEND_IMG && s_data_valid) || state == SEND_PAD;
        m_data       = state == SEND_IMG ? s_data : '0;
        o_busy       = state != IDLE;
        o_frame_done = state == DRAIN && out_cnt == TOTAL;
    end

    // frame FSM with column/line position and filtered-output counting
    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            state    <= IDLE;
            col      <= '0;
            line_idx <= '0;
            out_cnt  <= '0;
        end else begin
            if (state != IDLE && i_out_valid && out_cnt != TOTAL)
                out_cnt <= out_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state    <= SEND_IMG;
                        col      <= '0;
                        line_idx <= '0;
                        out_cnt  <= '0;
                    end
                end
                SEND_IMG, SEND_PAD: begin
                    if (xfer) begin
                        col <= line_end ? '0 : col + 1'b1;
                        if (line_end) begin
                            line_idx <= nline;
                            state    <= nline < LW'(PREFILL_LINES) ? SEND_IMG :
                                        nline == LAST             ? DRAIN :
                                        !avail                    ? WAIT_CREDIT :
                                        nline < LW'(IMG_H)        ? SEND_IMG : SEND_PAD;
                        end
                    end
                end
                WAIT_CREDIT: begin
                    if (avail)
                        state <= line_idx < LW'(IMG_H) ? SEND_IMG : SEND_PAD;
                end
                DRAIN: begin
                    if (o_frame_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_feed_sequencer.sv
// tb_image_feed_sequencer: scoreboard bench with randomized handshakes against a frame-level reference model
module tb_image_feed_sequencer;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int PRE = 4;
    localparam int PAD = 2;

    logic       axi_clk      = 1'b0;
    logic       axi_rst      = 1'b0;
    logic       i_start      = 1'b0;
    logic [7:0] s_data       = '0;
    logic       s_data_valid = 1'b0;
    logic       m_data_ready = 1'b0;
    logic       i_intr       = 1'b0;
    logic       i_out_valid  = 1'b0;
    logic       s_data_ready;
    logic [7:0] m_data;
    logic       m_data_valid;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_credit_ovf;

    typedef struct packed {
        logic [7:0] d;
        logic       pad;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   xfer_cnt = 0;
    int   edges    = 0;
    int   done_cnt = 0;
    int   d        = 0;
    bit   rnd      = 1'b0;
    bit   rdy_cmd  = 1'b1;
    bit   fired    = 1'b0;

    image_feed_sequencer #(
        .IMG_W(W), .IMG_H(H), .PREFILL_LINES(PRE), .PAD_LINES(PAD), .DW(8), .CREDIT_MAX(7)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_rst     (axi_rst),
        .i_start     (i_start),
        .s_data      (s_data),
        .s_data_valid(s_data_valid),
        .s_data_ready(s_data_ready),
        .m_data      (m_data),
        .m_data_valid(m_data_valid),
        .m_data_ready(m_data_ready),
        .i_intr      (i_intr),
        .i_out_valid (i_out_valid),
        .o_busy      (o_busy),
        .o_frame_done(o_frame_done),
        .o_credit_ovf(o_credit_ovf)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge axi_clk);
    endtask

    task automatic do_reset;
        axi_rst = 1'b0;
        step(2);
        exp_q.delete();
        xfer_cnt = 0;
        edges    = 0;
        done_cnt = 0;
        axi_rst  = 1'b1;
        step(1);
    endtask

    // reference frame: the upstream sequence in order, then PAD zero lines that never touch upstream
    task automatic start_frame;
        for (int i = 0; i < W * H; i++) exp_q.push_back('{d: 8'(i), pad: 1'b0});
        for (int i = 0; i < W * PAD; i++) exp_q.push_back('{d: 8'd0, pad: 1'b1});
        i_start = 1'b1;
        step(1);
        i_start = 1'b0;
    endtask

    task automatic pulse;
        i_intr = 1'b1;
        edges++;
        step(1);
        i_intr = 1'b0;
        step(1);
    endtask

    task automatic wait_xfers(input int n, input int lim);
        int c;
        c = 0;
        while (xfer_cnt < n && c < lim) begin
            step(1);
            c++;
        end
        chk("xfer_count", xfer_cnt, n);
    endtask

    // upstream source: incrementing data that advances only when accepted
    initial forever begin
        @(negedge axi_clk);
        if (!axi_rst) d = 0;
        else if (fired) d++;
        s_data       = 8'(d);
        s_data_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_data_ready = rnd ? ($urandom_range(0, 3) != 0) : rdy_cmd;
        #2;
        fired = axi_rst && s_data_valid && s_data_ready;
    end

    // monitor: every downstream transfer pops the scoreboard and must respect the credit budget
    initial begin
        exp_t e;
        forever begin
            @(negedge axi_clk);
            #2;
            if (axi_rst) begin
                if (o_frame_done) done_cnt++;
                if (m_data_valid && m_data_ready) begin
                    chk("credit_gate", ((xfer_cnt / W) < (PRE + edges)) ? 1 : 0, 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_xfer: got pixel %0d, expected none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e.d);
                        chk("s_data_ready", s_data_ready, !e.pad);
                    end
                    xfer_cnt++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        int nxt, outs, sent, c;
        step(2);
        #2;
        chk("rst_busy", o_busy, 0);
        chk("rst_mvalid", m_data_valid, 0);
        chk("rst_sready", s_data_ready, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_ovf", o_credit_ovf, 0);
        axi_rst = 1'b1;
        step(4);
        #2;
        chk("idle_busy", o_busy, 0);
        chk("idle_mvalid", m_data_valid, 0);
        chk("idle_sready", s_data_ready, 0);
        step(1);
        start_frame;
        step(5);
        chk("mid_busy", o_busy, 1);
        axi_rst = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_mvalid", m_data_valid, 0);
        chk("midrst_sready", s_data_ready, 0);
        chk("midrst_mdata", m_data, 0);

        do_reset;
        start_frame;
        wait_xfers(32, 60);
        step(10);
        #2;
        chk("prefill_only", xfer_cnt, 32);
        chk("wait_mvalid", m_data_valid, 0);
        chk("wait_sready", s_data_ready, 0);
        chk("wait_busy", o_busy, 1);
        step(1);
        i_intr = 1'b1;
        edges++;
        #2;
        chk("credit_not_yet", m_data_valid, 0);
        step(1);
        #2;
        chk("credit_release", m_data_valid, 1);
        i_intr = 1'b0;
        wait_xfers(40, 30);
        step(5);
        #2;
        chk("one_line", xfer_cnt, 40);
        chk("wait_again", m_data_valid, 0);

        do_reset;
        start_frame;
        step(3);
        pulse;
        pulse;
        step(40);
        #3;
        chk("no_gap", xfer_cnt, 48);
        step(5);
        #2;
        chk("stop_after_credits", xfer_cnt, 48);
        rdy_cmd = 1'b0;
        step(1);
        repeat (8) pulse;
        #2;
        chk("ovf_clear_at_7", o_credit_ovf, 0);
        chk("stalled", xfer_cnt, 48);
        pulse;
        #2;
        chk("ovf_set", o_credit_ovf, 1);
        rdy_cmd = 1'b1;
        wait_xfers(80, 120);
        step(3);
        #2;
        chk("drain_busy", o_busy, 1);
        chk("drain_no_done", done_cnt, 0);
        chk("pad_queue_empty", exp_q.size(), 0);
        i_out_valid = 1'b1;
        step(63);
        #2;
        chk("early_done", done_cnt, 0);
        step(1);
        i_out_valid = 1'b0;
        step(3);
        #2;
        chk("done_once", done_cnt, 1);
        chk("idle_after_done", o_busy, 0);
        chk("ovf_sticky", o_credit_ovf, 1);
        start_frame;
        #2;
        chk("ovf_cleared_on_start", o_credit_ovf, 0);

        do_reset;
        start_frame;
        for (int l = PRE; l < H + PAD; l++) begin
            c = 0;
            while (xfer_cnt < (l - 1) * W + 4 && c < 100) begin
                step(1);
                c++;
            end
            pulse;
        end
        wait_xfers(80, 100);
        step(2);
        #2;
        chk("pad_done_mvalid", m_data_valid, 0);
        chk("full_queue_empty", exp_q.size(), 0);
        chk("no_done_before_out", done_cnt, 0);
        repeat (64) begin
            i_out_valid = 1'b1;
            step(1);
            i_out_valid = 1'b0;
            step(1);
        end
        step(2);
        #2;
        chk("frame_done_once", done_cnt, 1);
        chk("frame_idle", o_busy, 0);

        for (int r = 0; r < 2; r++) begin
            do_reset;
            rnd = 1'b1;
            start_frame;
            nxt  = $urandom_range(0, 20);
            outs = 0;
            sent = 0;
            for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
                i_intr = (sent < H + PAD - PRE) && k >= nxt;
                if (i_intr) begin
                    edges++;
                    sent++;
                    nxt = k + $urandom_range(2, 30);
                end
                i_out_valid = (outs < W * H) && ($urandom_range(0, 1) == 1);
                if (i_out_valid) outs++;
                step(1);
            end
            i_intr      = 1'b0;
            i_out_valid = 1'b0;
            rnd         = 1'b0;
            step(2);
            #2;
            chk("rnd_xfers", xfer_cnt, 80);
            chk("rnd_done", done_cnt, 1);
            chk("rnd_queue", exp_q.size(), 0);
            chk("rnd_idle", o_busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_feed_sequencer.md
Name: image_feed_sequencer

Overview:
Hardware replacement for the software frame-feeding loop in front of imageprocesstop. Pulls a raster greyscale frame from an upstream valid/ready pixel stream and gates it into the line-buffered 3x3 filter core. First prefills PREFILL_LINES lines, then releases one line per o_intr credit from the core, then appends PAD_LINES zero lines. Counts filtered output pixels and flags frame completion.

Parameters:
IMG_W, 512, pixels per line
IMG_H, 512, image lines per frame
PREFILL_LINES, 4, lines sent at frame start without credit
PAD_LINES, 2, zero lines appended after the image, each needing a credit
DW, 8, pixel width
CREDIT_MAX, 7, saturation value of the line-credit counter

Ports:
axi_clk  in  1  clock
axi_rst  in  1  reset, asynchronous, active-low
i_start  in  1  1-cycle start request; accepted only in IDLE
s_data  in  DW  upstream pixel
s_data_valid  in  1  upstream pixel valid
s_data_ready  out  1  upstream ready
m_data  out  DW  pixel to core i_data
m_data_valid  out  1  to core i_data_valid
m_data_ready  in  1  core accept (tie 1 if unused)
i_intr  in  1  core o_intr (line buffer freed)
i_out_valid  in  1  core o_data_valid AND sink ready
o_busy  out  1  high in any state except IDLE
o_frame_done  out  1  1-cycle pulse at frame completion
o_credit_ovf  out  1  sticky: credit arrived while saturated

Behaviour:
- Reset (axi_rst=0, any time, including mid-line): state IDLE; all counters 0; s_data_ready=0, m_data_valid=0, m_data=0, o_busy=0, o_frame_done=0, o_credit_ovf=0.
- States: IDLE, SEND_IMG, WAIT_CREDIT, SEND_PAD, DRAIN.
- IDLE: i_start -> SEND_IMG, line=0, col=0, credits=0, out_cnt=0, o_credit_ovf cleared.
- SEND_IMG: combinational pass-through, zero added latency: m_data=s_data, m_data_valid=s_data_valid, s_data_ready=m_data_ready. Transfer = s_data_valid & m_data_ready. On each transfer col++. On col wrap (IMG_W-1 -> 0), line++. Next line chosen by the next-line rule below.
- Next-line rule after each completed line L (new line index L+1):
  - L+1 < PREFILL_LINES: stay SEND_IMG, no credit consumed.
  - L+1 = IMG_H + PAD_LINES: go DRAIN.
  - credits>0 (including the increment arriving the same cycle): consume 1 credit. Go SEND_IMG if L+1 < IMG_H, else SEND_PAD. No bubble between lines.
  - Otherwise go WAIT_CREDIT.
- WAIT_CREDIT: all valid/ready low. On credits>0, consume 1 and go SEND_IMG or SEND_PAD per line index. Entry to the send state is the next cycle.
- SEND_PAD: m_data=0, m_data_valid=1, s_data_ready=0. Upstream is never consumed. Transfer = m_data_ready. Line/col counting is identical to SEND_IMG.
- Credits: i_intr is rising-edge detected against a registered copy of i_intr. Each edge adds 1. Increment and consume in the same cycle leave the count unchanged. An edge at CREDIT_MAX is dropped and sets o_credit_ovf. Edges count in every non-IDLE state, including during prefill.
- out_cnt increments on i_out_valid in every non-IDLE state. Width is clog2(IMG_W*IMG_H+1).
- DRAIN: when out_cnt reaches IMG_W*IMG_H, o_frame_done=1 for one cycle, then IDLE. The count may be reached before DRAIN; in that case the pulse fires on the DRAIN entry cycle.
- i_start outside IDLE is ignored.
- Widths: col clog2(IMG_W); line clog2(IMG_H+PAD_LINES+1); credits clog2(CREDIT_MAX+1).

Decomposition:
- Package img_seq_pkg: state enum; default IMG_W/IMG_H/PREFILL_LINES/PAD_LINES constants; a clog2-based width localparam helper.
- One sub-module, line_credit_counter: i_intr edge detect, saturating credit counter with consume input, ovf flag.
- FSM and counters stay in image_feed_sequencer.

Test Plan:
(IMG_W=8, IMG_H=8, PREFILL_LINES=4, PAD_LINES=2, upstream always valid with incrementing data, m_data_ready=1 unless stated.)
1. Reset, then hold idle -> all outputs 0, o_busy=0. Assert axi_rst low mid-line -> same-cycle return to IDLE and outputs 0.
2. i_start, no intr -> exactly 32 transfers (data 0..31) on consecutive cycles, then WAIT_CREDIT with m_data_valid=0 indefinitely.
3. In WAIT_CREDIT, pulse i_intr once -> 8 transfers (32..39) starting 2 cycles after the edge, then back to WAIT_CREDIT.
4. Pulse i_intr twice during prefill -> lines 4 and 5 (data 32..47) follow line 3 with no gap; credits=0 afterwards. 8 extra edges with nothing consumed -> credits=7, o_credit_ovf=1.
5. Full frame with an intr after each line -> 64 image pixels, then 2x8 pad pixels with m_data=0 and s_data_ready=0. After 64 i_out_valid pulses, o_frame_done is high for exactly 1 cycle and the block returns to IDLE.
6. Random m_data_ready and s_data_valid bubbles -> downstream sequence equals upstream sequence, with no drop or duplication; line boundaries still gated by credits.
